// File: rtl/udp_payload_sequencer.sv
// UDP payload sequencer: packs N_PRL x BW sample words LSB-first into BW_OUT-bit bytes, framed as
// WORDS_PER_PKT-word packets. Define UDP_PAYLOAD_SEQ_HDR_EN to prepend a big-endian seq header.
module udp_payload_sequencer #(
    parameter int BW            = 18,
    parameter int N_PRL         = 4,
    parameter int BW_OUT        = 8,
    parameter int WORDS_PER_PKT = 16,
    parameter int SEQ_BYTES     = 4
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [N_PRL*BW-1:0]   x,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BW_OUT-1:0]     m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [31:0]           pkt_count,
    output logic [15:0]           underrun_cnt
);
    localparam int WW  = BW * N_PRL;
    localparam int BPW = WW / BW_OUT;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WCW = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

    if ((WW % BW_OUT) != 0) begin : g_bad_width
        $error("BW*N_PRL must be a multiple of BW_OUT");
    end
    if (WORDS_PER_PKT < 1 || SEQ_BYTES < 1) begin : g_bad_len
        $error("WORDS_PER_PKT and SEQ_BYTES must be at least 1");
    end

`ifdef UDP_PAYLOAD_SEQ_HDR_EN
    localparam int HIW  = (SEQ_BYTES > 1) ? $clog2(SEQ_BYTES) : 1;
    localparam int HDRW = SEQ_BYTES * BW_OUT;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;
    localparam state_t S_FIRST = S_HDR;
    logic [HIW-1:0]                      hdr_idx_q, hdr_idx_d;
    logic [SEQ_BYTES-1:0][BW_OUT-1:0]    hdr_w;
`else
    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;
    localparam state_t S_FIRST = S_PAYLOAD;
`endif

    state_t                     state_q, state_d;
    logic [BPW-1:0][BW_OUT-1:0] buf_q, buf_d;
    logic                       buf_full_q, buf_full_d;
    logic [BIW-1:0]             byte_idx_q, byte_idx_d;
    logic [WCW-1:0]             word_cnt_q, word_cnt_d;
    logic [31:0]                seq_q, seq_d;
    logic [31:0]                pkt_q, pkt_d;
    logic [15:0]                und_q, und_d;
    logic                       rdy_en_q;
    logic                       take, last_take, capture;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        seq_d      = seq_q;
        pkt_d      = pkt_q;
        und_d      = und_q;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
`ifdef UDP_PAYLOAD_SEQ_HDR_EN
        hdr_idx_d  = hdr_idx_q;
        hdr_w      = HDRW'(seq_q);
`endif
        case (state_q)
`ifdef UDP_PAYLOAD_SEQ_HDR_EN
            S_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = hdr_w[HIW'(SEQ_BYTES - 1) - hdr_idx_q];
            end
`endif
            S_PAYLOAD: begin
                m_tvalid = buf_full_q;
                m_tdata  = buf_full_q ? buf_q[byte_idx_q] : '0;
                m_tlast  = buf_full_q && (word_cnt_q == WCW'(WORDS_PER_PKT - 1))
                           && (byte_idx_q == BIW'(BPW - 1));
            end
            default: ;
        endcase

        take      = m_tvalid && m_tready;
        last_take = (state_q == S_PAYLOAD) && take && (byte_idx_q == BIW'(BPW - 1));
        // Refill on the final byte of the held word so consecutive words stream without a gap.
        in_ready  = rdy_en_q && (!buf_full_q || last_take);
        capture   = in_valid && in_ready;

        if (capture) begin
            buf_d      = x;
            buf_full_d = 1'b1;
        end else if (last_take) begin
            buf_full_d = 1'b0;
        end

        if (state_q == S_PAYLOAD && !buf_full_q && und_q != 16'hFFFF)
            und_d = und_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (buf_full_q || capture) state_d = S_FIRST;
            end
`ifdef UDP_PAYLOAD_SEQ_HDR_EN
            S_HDR: begin
                if (take) begin
                    if (hdr_idx_q == HIW'(SEQ_BYTES - 1)) begin
                        hdr_idx_d = '0;
                        state_d   = S_PAYLOAD;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 1'b1;
                    end
                end
            end
`endif
            S_PAYLOAD: begin
                if (take) begin
                    if (byte_idx_q == BIW'(BPW - 1)) begin
                        byte_idx_d = '0;
                        if (word_cnt_q == WCW'(WORDS_PER_PKT - 1)) begin
                            word_cnt_d = '0;
                            seq_d      = seq_q + 32'd1;
                            pkt_d      = pkt_q + 32'd1;
                            state_d    = buf_full_d ? S_FIRST : S_IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            seq_q      <= '0;
            pkt_q      <= '0;
            und_q      <= '0;
            rdy_en_q   <= 1'b0;
`ifdef UDP_PAYLOAD_SEQ_HDR_EN
            hdr_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
            seq_q      <= seq_d;
            pkt_q      <= pkt_d;
            und_q      <= und_d;
            rdy_en_q   <= 1'b1;
`ifdef UDP_PAYLOAD_SEQ_HDR_EN
            hdr_idx_q  <= hdr_idx_d;
`endif
        end
    end

    assign pkt_count    = pkt_q;
    assign underrun_cnt = und_q;

endmodule

// File: tb/tb_udp_payload_sequencer.sv
// Bench for udp_payload_sequencer: directed scenarios plus randomized traffic, checked against a
// packet-level byte-queue model built from accepted words.
module tb_udp_payload_sequencer;
    localparam int BW = 18, N_PRL = 4, BW_OUT = 8, WPP = 2, SEQ_BYTES = 4;
    localparam int WW = BW * N_PRL, BPW = WW / BW_OUT;
`ifdef UDP_PAYLOAD_SEQ_HDR_EN
    localparam int HDR_LEN = SEQ_BYTES;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int PKT_LEN = HDR_LEN + WPP * BPW;

    logic          clk = 1'b0, srst_n = 1'b0;
    logic [WW-1:0] x = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready = 1'b0, m_tlast;
    logic [31:0]   pkt_count;
    logic [15:0]   underrun_cnt;

    udp_payload_sequencer #(.BW(BW), .N_PRL(N_PRL), .BW_OUT(BW_OUT),
                            .WORDS_PER_PKT(WPP), .SEQ_BYTES(SEQ_BYTES)) dut (
        .clk(clk), .srst_n(srst_n), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .pkt_count(pkt_count), .underrun_cnt(underrun_cnt));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [8:0]    exp_q[$];
    logic [WW-1:0] send_q[$];
    int   acc_words = 0, exp_pkts = 0, bytes_seen = 0, cyc = 0;
    int   first_hs = -1, last_hs = -1;
    int   in_pct = 100, rdy_mode = 0, rdy_ph = 0;
    logic stall_prev = 1'b0;
    logic [8:0] held = '0;

    // Expected packet: optional MSB-first header of the packet number, then LSB-first word bytes.
    function automatic void model_word(input logic [WW-1:0] w);
        int pos = acc_words % WPP;
        logic [31:0] s = 32'(acc_words / WPP);
        if (pos == 0)
            for (int b = HDR_LEN - 1; b >= 0; b--) exp_q.push_back({1'b0, s[8*b +: 8]});
        for (int j = 0; j < BPW; j++)
            exp_q.push_back({(pos == WPP - 1) && (j == BPW - 1), w[8*j +: 8]});
        acc_words++;
    endfunction

    task automatic cycle();
        logic acc;
        logic [8:0] e;
        @(negedge clk);
        cyc++;
        if (stall_prev) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data_last", {m_tlast, m_tdata}, held);
        end
        if (m_tvalid && m_tready) begin
            bytes_seen++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            chk("byte_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("byte_last_data", {m_tlast, m_tdata}, e);
                if (e[8]) exp_pkts++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) model_word(x);
        stall_prev = m_tvalid && !m_tready;
        held = {m_tlast, m_tdata};
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
        if (!in_valid && send_q.size() > 0 && $urandom_range(99) < in_pct) begin
            x = send_q.pop_front();
            in_valid = 1'b1;
        end
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: begin m_tready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || send_q.size() != 0 || in_valid) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, n < budget, 1);
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        w[31:0]  = $urandom;
        w[63:32] = $urandom;
        w[71:64] = 8'($urandom);
        return w;
    endfunction

    initial begin
        int b0, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_underrun", underrun_cnt, 0);
        @(negedge clk);
        srst_n = 1'b1;
        #1 chk("release_in_ready", in_ready, 0);
        @(posedge clk);
        #1;

        // single packet from the reference words
        m_tready = 1'b1; rdy_mode = 0; in_pct = 100;
        send_q.push_back(72'h0_0000_0001_2345_6789);
        send_q.push_back(72'h1);
        b0 = bytes_seen;
        drain("single", 200);
        chk("single_bytes", bytes_seen - b0, PKT_LEN);
        chk("single_pkt_count", pkt_count, 1);

        // back-to-back packets must stream without bubbles
        first_hs = -1;
        b0 = bytes_seen;
        for (int i = 0; i < 2 * WPP; i++) send_q.push_back(rand_word());
        drain("b2b", 300);
        chk("b2b_bytes", bytes_seen - b0, 2 * PKT_LEN);
        chk("b2b_no_bubble", last_hs - first_hs + 1, 2 * PKT_LEN);
        chk("b2b_pkt_count", pkt_count, 3);

        // underrun: second word arrives 10 cycles after the first word's last byte
        b0 = bytes_seen;
        send_q.push_back(rand_word());
        n = 0;
        while (bytes_seen - b0 < HDR_LEN + BPW && n < 100) begin cycle(); n++; end
        chk("underrun_first_word", n < 100, 1);
        for (int i = 0; i < 9; i++) begin
            chk("underrun_tvalid", m_tvalid, 0);
            cycle();
        end
        x = rand_word();
        in_valid = 1'b1;
        drain("underrun", 200);
        chk("underrun_cnt", underrun_cnt, 10);
        chk("underrun_pkt_count", pkt_count, 4);

        // backpressure with a 1,0,0,1 ready pattern
        rdy_mode = 1; rdy_ph = 0;
        b0 = bytes_seen;
        for (int i = 0; i < 2 * WPP; i++) send_q.push_back(rand_word());
        drain("bp", 600);
        chk("bp_bytes", bytes_seen - b0, 2 * PKT_LEN);
        chk("bp_pkt_count", pkt_count, 6);

        // randomized ready and input gaps
        rdy_mode = 2; in_pct = 40;
        for (int i = 0; i < 6 * WPP; i++) send_q.push_back(rand_word());
        drain("rand", 3000);
        chk("rand_pkt_count", pkt_count, 12);
        chk("model_pkt_count", pkt_count, 32'(exp_pkts));

        // reset mid-packet after byte 7
        rdy_mode = 0; in_pct = 100; m_tready = 1'b1;
        b0 = bytes_seen;
        send_q.push_back(rand_word());
        send_q.push_back(rand_word());
        n = 0;
        while (bytes_seen - b0 < 7 && n < 100) begin cycle(); n++; end
        chk("midrst_reach", n < 100, 1);
        #2 srst_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_tdata", m_tdata, 0);
        chk("midrst_tlast", m_tlast, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_pkt_count", pkt_count, 0);
        chk("midrst_underrun", underrun_cnt, 0);
        exp_q.delete(); send_q.delete();
        in_valid = 1'b0; acc_words = 0; exp_pkts = 0; stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        srst_n = 1'b1;
        #1 chk("midrst_release_ready", in_ready, 0);
        @(posedge clk);
        #1;
        b0 = bytes_seen;
        send_q.push_back(rand_word());
        send_q.push_back(rand_word());
        drain("after_rst", 200);
        chk("after_rst_bytes", bytes_seen - b0, PKT_LEN);
        chk("after_rst_pkt_count", pkt_count, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/udp_payload_sequencer.md
Name: udp_payload_sequencer

Overview:
- Sequences the UDP payload datapath: accepts parallel sample words (N_PRL lanes of BW bits), packs them LSB-first into BW_OUT-bit bytes and streams them out over a valid/ready byte stream.
- Each packet is a fixed-length frame: a big-endian sequence-number header followed by WORDS_PER_PKT packed words, with tlast on the final byte.
- Sits between the sample-concatenation stage and the UDP/IP header inserter.

Parameters:
- BW, 18, bits per sample lane.
- N_PRL, 4, parallel lanes per input word.
- BW_OUT, 8, output byte width; BW*N_PRL must be divisible by BW_OUT (elaboration error otherwise).
- WORDS_PER_PKT, 16, input words per packet, >=1.
- SEQ_BYTES, 4, header length in bytes; header = low SEQ_BYTES*BW_OUT bits of seq counter.
- Derived: BPW = BW*N_PRL/BW_OUT bytes per word (9 at defaults).

Ports:
- clk, in, 1, clock.
- srst_n, in, 1, asynchronous active-low reset.
- x, in, N_PRL*BW, input word; lane i at bits [BW*i +: BW].
- in_valid, in, 1, x valid.
- in_ready, out, 1, word accepted when in_valid & in_ready.
- m_tdata, out, BW_OUT, output byte.
- m_tvalid, out, 1, byte valid.
- m_tready, in, 1, downstream ready.
- m_tlast, out, 1, last byte of packet.
- pkt_count, out, 32, packets completed (tlast handshakes), wraps.
- underrun_cnt, out, 16, cycles in PAYLOAD with buffer empty; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release): state=IDLE, buffer empty, byte_idx=0, word_cnt=0, seq=0, pkt_count=0, underrun_cnt=0; m_tvalid=0, m_tlast=0, m_tdata=0, in_ready=0.
- in_ready is 0 during reset and for the first cycle after release. Afterwards: in_ready = ~buf_full | (state==PAYLOAD & byte_idx==BPW-1 & m_tvalid & m_tready).
- Handshake fires on the last byte of the buffered word, so back-to-back words stream with no bubble.
- Buffer: one word register, captured on the in_valid & in_ready handshake; buf_full set on capture, cleared when its last byte handshakes without a simultaneous capture.
- Byte order: byte j of a word = word[BW_OUT*j +: BW_OUT], for j = 0..BPW-1.
- FSM states:
  - IDLE: m_tvalid=0. On buf_full, go to HDR.
  - HDR: emits SEQ_BYTES bytes of seq, MSB first, one per m_tready handshake. After the last header byte, go to PAYLOAD.
  - PAYLOAD: m_tvalid = buf_full, m_tdata = byte byte_idx of the buffer. On each handshake byte_idx++. At BPW-1, byte_idx wraps to 0 and word_cnt++.
    - m_tlast = (word_cnt==WORDS_PER_PKT-1) & (byte_idx==BPW-1).
    - tlast handshake: seq++, pkt_count++, word_cnt=0, go to IDLE, or go straight to HDR if a word is captured or held that cycle.
- Output latency: first header byte is valid 1 cycle after the capturing input handshake, i.e. m_tvalid rises the cycle after in_valid & in_ready.
- Stream rules:
  - While m_tvalid=1 & m_tready=0, m_tdata and m_tlast hold stable.
  - m_tvalid never drops without a handshake, except on reset.
- Underrun: in PAYLOAD with buf_full=0, m_tvalid=0 and the packet stalls; no padding. underrun_cnt increments each such cycle.
- Input stall: input is not accepted while buffer full and the last byte is not being taken; upstream must hold x/in_valid.
- Wrap-around: seq and pkt_count wrap modulo 2^32; seq header truncates to SEQ_BYTES bytes.
- Reset mid-packet: the packet is abandoned immediately (no tlast); after release, sequencing restarts with seq=0.

Optional Feature:
- Macro: UDP_PAYLOAD_SEQ_HDR_EN.
- Defined: HDR state present, header bytes emitted as above.
- Undefined: no HDR state and no seq header.
  - IDLE goes to PAYLOAD directly when buf_full.
  - Packet length = WORDS_PER_PKT*BPW bytes.
  - seq is still counted and not output; pkt_count is unchanged in behaviour.

Test Plan (BW=18, N_PRL=4, BW_OUT=8, WORDS_PER_PKT=2, SEQ_BYTES=4, BPW=9, HDR_EN defined):
- Single packet, m_tready=1, two words x=0x0_0000_0001_2345_6789 then 0x1: 22 bytes, 00 00 00 00, then 89 67 45 23 01 00 00 00 00, then 01 and 8×00. tlast only on byte 22; pkt_count=1.
- Two back-to-back packets, in_valid held: second header = 00 00 00 01; no idle cycle between word bytes within a packet; in_ready pulses on each 9th payload byte.
- Backpressure: m_tready toggles 1,0,0,1 pattern. m_tdata/m_tvalid/m_tlast hold while stalled; total bytes still 22 per packet, order unchanged.
- Underrun: second word delayed 10 cycles after the first word's last byte → m_tvalid=0 for 10 cycles, underrun_cnt=10, packet completes correctly.
- Reset asserted on byte 7 of packet 0: outputs zero asynchronously. After release, the next packet header = 00 00 00 00 and pkt_count=0.
- HDR_EN undefined: same stimulus as the first scenario → 18 bytes, no header, tlast on byte 18.
